// File: rtl/hmac_stream_pkg.sv
// hmac_stream_pkg
//   Shared constants for the multi-block HMAC-SHA-384/512 engine:
//   FSM state encodings, ipad/opad bytes, the fixed final-block pads
//   for the outer hash, and the latched mode encodings.
package hmac_stream_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_IPAD  = 3'd1;
    localparam logic [2:0] ST_MSG   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_OUTER = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [7:0] IPAD_BYTE = 8'h36;
    localparam logic [7:0] OPAD_BYTE = 8'h5c;

    // Outer message = 128-byte opad block + inner digest.
    // SHA-384: 176 bytes = 0x580 bits; SHA-512: 192 bytes = 0x600 bits.
    localparam logic [639:0] HMAC384_FINAL_PAD = {8'h80, 504'b0, 128'h580};
    localparam logic [511:0] HMAC512_FINAL_PAD = {8'h80, 376'b0, 128'h600};

    localparam logic [1:0] MODE_SHA384 = 2'b10;
    localparam logic [1:0] MODE_SHA512 = 2'b11;

endpackage

// File: rtl/hmac_lfsr.sv
// hmac_lfsr
//   One Galois LFSR of the entropy bank. Free-runs every cycle, loads
//   the external seed on load (falls back to SEED if that seed is zero,
//   since an all-zero Galois LFSR never leaves zero). zeroize restores SEED.
// Ports: clk, reset_n, zeroize, load, seed[LFSR_W-1:0] -> state[LFSR_W-1:0]
module hmac_lfsr #(
    parameter int                 LFSR_W = 32,
    parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'('h80200003),
    parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              zeroize,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
        if (zeroize)
            lfsr_d = SEED;
        else if (load)
            lfsr_d = (seed == '0) ? SEED : seed;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign state = lfsr_q;

endmodule

// File: rtl/hmac_lfsr_bank.sv
// hmac_lfsr_bank
//   NUM_LFSR independent LFSRs concatenated into a 384-bit entropy word.
//   load reseeds all of them from lfsr_seed.
// Ports: clk, reset_n, zeroize, load, lfsr_seed[383:0] -> entropy[383:0]
module hmac_lfsr_bank #(
    parameter logic [383:0] LFSR_INIT_SEED = '1,
    parameter int           NUM_LFSR       = 12,
    parameter int           LFSR_W         = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         zeroize,
    input  logic         load,
    input  logic [383:0] lfsr_seed,
    output logic [383:0] entropy
);
    if (NUM_LFSR * LFSR_W != 384) begin : g_bad_cfg
        $error("hmac_lfsr_bank: NUM_LFSR*LFSR_W must equal 384");
    end

    for (genvar i = 0; i < NUM_LFSR; i++) begin : g_lfsr
        hmac_lfsr #(
            .LFSR_W (LFSR_W),
            .SEED   (LFSR_INIT_SEED[i*LFSR_W +: LFSR_W])
        ) u_lfsr (
            .clk     (clk),
            .reset_n (reset_n),
            .zeroize (zeroize),
            .load    (load),
            .seed    (lfsr_seed[i*LFSR_W +: LFSR_W]),
            .state   (entropy[i*LFSR_W +: LFSR_W])
        );
    end

endmodule

// File: rtl/sha512_masked_core.sv
// sha512_masked_core
//   Iterative SHA-384/512 compression, one round per cycle (80 rounds).
//   init_cmd loads the IV selected by mode512 and compresses block;
//   next_cmd compresses block onto the current chaining value.
//   The message schedule window is stored XORed with a per-block mask
//   folded from entropy, so raw message words never sit in flops.
// Ports: clk, reset_n, zeroize, init_cmd, next_cmd, mode512, block[1023:0],
//        entropy[191:0] -> ready, digest[511:0] (H0 in [511:448])
module sha512_masked_core (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          zeroize,
    input  logic          init_cmd,
    input  logic          next_cmd,
    input  logic          mode512,
    input  logic [1023:0] block,
    input  logic [191:0]  entropy,
    output logic          ready,
    output logic [511:0]  digest
);
    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

    localparam logic [63:0] IV512 [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [63:0] IV384 [8] = '{
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // index 0 = a ... 7 = h
    logic [7:0][63:0]  h_q, h_d, v_q, v_d, nv, h_start;
    logic [15:0][63:0] w_q, w_d;
    logic [63:0]       mask_q, mask_d, m_new, wt, w1u, w9u, w14u, wnew, t1, t2;
    logic [6:0]        rnd_q, rnd_d;
    logic              busy_q, busy_d;

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        w_d    = w_q;
        mask_d = mask_q;
        rnd_d  = rnd_q;
        busy_d = busy_q;

        m_new = entropy[63:0] ^ entropy[127:64] ^ entropy[191:128];
        wt    = w_q[0]  ^ mask_q;
        w1u   = w_q[1]  ^ mask_q;
        w9u   = w_q[9]  ^ mask_q;
        w14u  = w_q[14] ^ mask_q;
        wnew  = (rotr(w14u, 19) ^ rotr(w14u, 61) ^ (w14u >> 6)) + w9u
              + (rotr(w1u, 1) ^ rotr(w1u, 8) ^ (w1u >> 7)) + wt;

        t1 = v_q[7] + (rotr(v_q[4], 14) ^ rotr(v_q[4], 18) ^ rotr(v_q[4], 41))
           + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[rnd_q] + wt;
        t2 = (rotr(v_q[0], 28) ^ rotr(v_q[0], 34) ^ rotr(v_q[0], 39))
           + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        nv = {v_q[6], v_q[5], v_q[4], v_q[3] + t1, v_q[2], v_q[1], v_q[0], t1 + t2};

        for (int i = 0; i < 8; i++)
            h_start[i] = init_cmd ? (mode512 ? IV512[i] : IV384[i]) : h_q[i];

        if (zeroize) begin
            h_d    = '0;
            v_d    = '0;
            w_d    = '0;
            mask_d = '0;
            rnd_d  = '0;
            busy_d = 1'b0;
        end else if (!busy_q && (init_cmd || next_cmd)) begin
            h_d    = h_start;
            v_d    = h_start;
            for (int i = 0; i < 16; i++)
                w_d[i] = block[1023-64*i -: 64] ^ m_new;
            mask_d = m_new;
            rnd_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            v_d = nv;
            for (int i = 0; i < 15; i++)
                w_d[i] = w_q[i+1];
            w_d[15] = wnew ^ mask_q;
            rnd_d   = rnd_q + 7'd1;
            if (rnd_q == 7'd79) begin
                busy_d = 1'b0;
                for (int i = 0; i < 8; i++)
                    h_d[i] = h_q[i] + nv[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q    <= '0;
            v_q    <= '0;
            w_q    <= '0;
            mask_q <= '0;
            rnd_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            w_q    <= w_d;
            mask_q <= mask_d;
            rnd_q  <= rnd_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        digest = '0;
        for (int i = 0; i < 8; i++)
            digest[511-64*i -: 64] = h_q[i];
    end

    assign ready = !busy_q;

endmodule

// File: rtl/hmac_stream_core.sv
// hmac_stream_core
//   Multi-block HMAC-SHA-384/512. One session = init_cmd (key + first block)
//   followed by any number of next_cmd blocks; last_cmd marks the final one.
//   H1 absorbs ipad + message blocks, H2 absorbs opad up front and the padded
//   inner digest once, after the last block. One tag per session.
// Ports: clk, reset_n, zeroize, init_cmd, next_cmd, last_cmd, mode_cmd,
//        lfsr_seed[383:0], key[511:0], block_msg[1023:0]
//        -> ready, tag_valid, tag[511:0], blk_cnt[CNT_W-1:0], cmd_err
// Build option: HMAC_KEY_LATCH_EN registers the key on init so the key port
//   is free after the handshake; otherwise the key must be held until tag_valid.
module hmac_stream_core
    import hmac_stream_pkg::*;
#(
    parameter logic [383:0] LFSR_INIT_SEED = 384'hc48555929cd58779f4819c1e6570c2ef20bccd503284e2d366f3273a66e9719b07ac999c80740d6277af88ceb4c3029c,
    parameter int           NUM_LFSR       = 12,
    parameter int           LFSR_W         = 32,
    parameter int           CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             zeroize,
    input  logic             init_cmd,
    input  logic             next_cmd,
    input  logic             last_cmd,
    input  logic             mode_cmd,
    input  logic [383:0]     lfsr_seed,
    input  logic [511:0]     key,
    input  logic [1023:0]    block_msg,
    output logic             ready,
    output logic             tag_valid,
    output logic [511:0]     tag,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             cmd_err
);
    logic [2:0]       state_q, state_d, prev_state_q, prev_state_d;
    logic [1:0]       mode_q, mode_d;
    logic             last_q, last_d, tag_valid_q, tag_valid_d;
    logic             cmd_err_q, cmd_err_d, sess_q, sess_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             first, acc_init, acc_next, mode512;
    logic             h1_init, h2_init, h1_next, h2_next, h1_ready, h2_ready;
    logic [511:0]     key_eff, h1_digest, h2_digest;
    logic [1023:0]    ipad_blk, opad_blk, outer_blk, h1_block, h2_block;
    logic [383:0]     entropy;

    assign ready    = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    assign acc_init = ready && init_cmd;
    assign acc_next = ready && next_cmd && !init_cmd;
    // Each busy state issues its command only on the cycle it is entered.
    assign first    = (state_q != prev_state_q);
    assign mode512  = (mode_q == MODE_SHA512);

`ifdef HMAC_KEY_LATCH_EN
    logic [511:0] key_q, key_d;

    always_comb begin
        key_d = key_q;
        if (zeroize)                 key_d = '0;
        else if (acc_init)           key_d = key;
        else if (state_q == ST_DONE) key_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) key_q <= '0;
        else          key_q <= key_d;
    end

    assign key_eff = key_q;
`else
    assign key_eff = key;
`endif

    assign ipad_blk  = {key_eff, 512'b0} ^ {128{IPAD_BYTE}};
    assign opad_blk  = {key_eff, 512'b0} ^ {128{OPAD_BYTE}};
    assign outer_blk = mode512 ? {h1_digest, HMAC512_FINAL_PAD}
                               : {h1_digest[511:128], HMAC384_FINAL_PAD};
    assign h1_block  = h1_init ? ipad_blk : block_msg;
    assign h2_block  = h2_init ? opad_blk : outer_blk;

    always_comb begin
        state_d      = state_q;
        prev_state_d = state_q;
        mode_d       = mode_q;
        last_d       = last_q;
        tag_valid_d  = tag_valid_q;
        blk_cnt_d    = blk_cnt_q;
        sess_d       = sess_q;
        cmd_err_d    = 1'b0;
        h1_init      = 1'b0;
        h2_init      = 1'b0;
        h1_next      = 1'b0;
        h2_next      = 1'b0;

        if (zeroize) begin
            state_d     = ST_IDLE;
            mode_d      = MODE_SHA384;
            last_d      = 1'b0;
            tag_valid_d = 1'b0;
            blk_cnt_d   = '0;
            sess_d      = 1'b0;
        end else if (acc_init) begin
            // From IDLE or WAIT alike; an open session is simply dropped.
            mode_d      = {1'b1, mode_cmd};
            last_d      = last_cmd;
            tag_valid_d = 1'b0;
            blk_cnt_d   = '0;
            state_d     = ST_IPAD;
        end else begin
            case (state_q)
                ST_IDLE: if (acc_next && !sess_q) cmd_err_d = 1'b1;
                ST_IPAD: begin
                    h1_init = first;
                    h2_init = first;
                    if (!first && h1_ready && h2_ready) state_d = ST_MSG;
                end
                ST_MSG: begin
                    h1_next = first;
                    if (!first && h1_ready) begin
                        if (blk_cnt_q != '1) blk_cnt_d = blk_cnt_q + CNT_W'(1);
                        sess_d  = 1'b1;
                        state_d = last_q ? ST_OUTER : ST_WAIT;
                    end
                end
                ST_WAIT: if (acc_next) begin
                    last_d  = last_cmd;
                    state_d = ST_MSG;
                end
                ST_OUTER: begin
                    h2_next = first;
                    if (!first && h2_ready) state_d = ST_DONE;
                end
                ST_DONE: begin
                    tag_valid_d = 1'b1;
                    sess_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prev_state_q <= ST_IDLE;
            mode_q       <= MODE_SHA384;
            last_q       <= 1'b0;
            tag_valid_q  <= 1'b0;
            blk_cnt_q    <= '0;
            sess_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_state_q <= prev_state_d;
            mode_q       <= mode_d;
            last_q       <= last_d;
            tag_valid_q  <= tag_valid_d;
            blk_cnt_q    <= blk_cnt_d;
            sess_q       <= sess_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    hmac_lfsr_bank #(
        .LFSR_INIT_SEED (LFSR_INIT_SEED),
        .NUM_LFSR       (NUM_LFSR),
        .LFSR_W         (LFSR_W)
    ) u_lfsr_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .zeroize   (zeroize),
        .load      (acc_init && !zeroize),
        .lfsr_seed (lfsr_seed),
        .entropy   (entropy)
    );

    sha512_masked_core u_h1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .zeroize  (zeroize),
        .init_cmd (h1_init),
        .next_cmd (h1_next),
        .mode512  (mode512),
        .block    (h1_block),
        .entropy  (entropy[191:0]),
        .ready    (h1_ready),
        .digest   (h1_digest)
    );

    sha512_masked_core u_h2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .zeroize  (zeroize),
        .init_cmd (h2_init),
        .next_cmd (h2_next),
        .mode512  (mode512),
        .block    (h2_block),
        .entropy  (entropy[383:192]),
        .ready    (h2_ready),
        .digest   (h2_digest)
    );

    assign tag       = h2_digest;
    assign tag_valid = tag_valid_q;
    assign blk_cnt   = blk_cnt_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_hmac_stream_core.sv
// tb_hmac_stream_core
//   Directed bench for hmac_stream_core: RFC4231 TC2 in both modes, a
//   3-block session against a behavioural HMAC model, illegal next_cmd,
//   session abandon and zeroize during the outer hash.
module tb_hmac_stream_core;
    import hmac_stream_pkg::*;

    localparam logic [511:0] TC2_512 = 512'h164b7a7bfcf819e2e395fbe73b56e0a387bd64222e831fd610270cd7ea2505549758bf75c05a994a6d034f65f8f0e6fdcaeab1a34d4a6b4b636e070a38bce737;
    localparam logic [383:0] TC2_384 = 384'haf45d2e376484031617f78d2b58a6b1b9c7ef464f5a01b47e42ec3736322445e8e2240ca5e69e2c78b3239ecfab21649;

    localparam logic [63:0] KT [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};
    localparam logic [63:0] IV5 [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [63:0] IV3 [8] = '{
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};

    logic          clk = 1'b0;
    logic          reset_n, zeroize, init_cmd, next_cmd, last_cmd, mode_cmd;
    logic [383:0]  lfsr_seed;
    logic [511:0]  key;
    logic [1023:0] block_msg;
    logic          ready, tag_valid, cmd_err;
    logic [511:0]  tag;
    logic [15:0]   blk_cnt;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    hmac_stream_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .zeroize   (zeroize),
        .init_cmd  (init_cmd),
        .next_cmd  (next_cmd),
        .last_cmd  (last_cmd),
        .mode_cmd  (mode_cmd),
        .lfsr_seed (lfsr_seed),
        .key       (key),
        .block_msg (block_msg),
        .ready     (ready),
        .tag_valid (tag_valid),
        .tag       (tag),
        .blk_cnt   (blk_cnt),
        .cmd_err   (cmd_err)
    );

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        for (int c = 0; c < 1000 && !ready; c++) tick();
        chk(name, ready, 1'b1);
    endtask

    task automatic wait_tag(input string name);
        for (int c = 0; c < 2000 && !tag_valid; c++) tick();
        chk(name, tag_valid, 1'b1);
    endtask

    task automatic send(input logic i, input logic n, input logic l, input logic m,
                        input logic [511:0] k, input logic [1023:0] b);
        wait_ready("send_ready");
        init_cmd  = i;
        next_cmd  = n;
        last_cmd  = l;
        mode_cmd  = m;
        key       = k;
        block_msg = b;
        tick();
        init_cmd  = 1'b0;
        next_cmd  = 1'b0;
        last_cmd  = 1'b0;
    endtask

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [511:0] sha_model(input bit m512, input logic [4095:0] msg, input int nblk);
        logic [63:0] h [8];
        logic [63:0] v [8];
        logic [63:0] w [80];
        logic [63:0] t1, t2;
        for (int i = 0; i < 8; i++) h[i] = m512 ? IV5[i] : IV3[i];
        for (int b = 0; b < nblk; b++) begin
            for (int t = 0; t < 16; t++) w[t] = msg[4095 - 1024*b - 64*t -: 64];
            for (int t = 16; t < 80; t++)
                w[t] = (rr(w[t-2], 19) ^ rr(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
                     + (rr(w[t-15], 1) ^ rr(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
            for (int i = 0; i < 8; i++) v[i] = h[i];
            for (int t = 0; t < 80; t++) begin
                t1 = v[7] + (rr(v[4], 14) ^ rr(v[4], 18) ^ rr(v[4], 41))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
                t2 = (rr(v[0], 28) ^ rr(v[0], 34) ^ rr(v[0], 39))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int i = 7; i > 0; i--) v[i] = v[i-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic logic [511:0] hmac_model(input bit m512, input logic [511:0] k,
                                                input logic [3071:0] msgs, input int n);
        logic [511:0]  inner;
        logic [1023:0] ob;
        inner = sha_model(m512, {{k, 512'b0} ^ {128{8'h36}}, msgs}, n + 1);
        ob = m512 ? {inner, 8'h80, 376'b0, 128'h600}
                  : {inner[511:128], 8'h80, 504'b0, 128'h580};
        return sha_model(m512, {{k, 512'b0} ^ {128{8'h5c}}, ob, 2048'b0}, 2);
    endfunction

    initial begin
        logic [511:0]  jefe, key3, keya, exp3;
        logic [1023:0] tc2, b0, b1, b2;

        jefe = {32'h4a656665, 480'b0};
        key3 = {16{32'h0badc0de}};
        keya = {8{64'hdeadbeef01234567}};
        tc2  = '0;
        tc2[1023 -: 224] = "what do ya want for nothing?";
        tc2[799 -: 8]    = 8'h80;
        tc2[127:0]       = 128'h4e0;
        b0 = {16{64'h0123456789abcdef}};
        b1 = {8{128'hfedcba98765432100f1e2d3c4b5a6978}};
        b2 = {32{32'hcafef00d}};

        reset_n = 1'b0; zeroize = 1'b0; init_cmd = 1'b0; next_cmd = 1'b0;
        last_cmd = 1'b0; mode_cmd = 1'b0; key = '0; block_msg = '0;
        lfsr_seed = {12{32'h13579bdf}};
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        chk("rst_ready", ready, 1'b1);
        chk("rst_tag_valid", tag_valid, 1'b0);
        chk("rst_blk_cnt", blk_cnt, 16'd0);
        chk("rst_cmd_err", cmd_err, 1'b0);

        // next_cmd with no open session
        next_cmd = 1'b1;
        tick();
        next_cmd = 1'b0;
        chk("err_pulse", cmd_err, 1'b1);
        chk("err_state", dut.state_q, ST_IDLE);
        chk("err_blk_cnt", blk_cnt, 16'd0);
        tick();
        chk("err_one_cycle", cmd_err, 1'b0);

        chk("model_tc2", hmac_model(1'b1, jefe, {tc2, 2048'b0}, 1), TC2_512);

        // TC2, HMAC-SHA-512
        send(1'b1, 1'b0, 1'b1, 1'b1, jefe, tc2);
        chk("tc2_512_busy", ready, 1'b0);
        wait_tag("tc2_512_done");
        chk("tc2_512_tag", tag, TC2_512);
        chk("tc2_512_cnt", blk_cnt, 16'd1);

        // TC2, HMAC-SHA-384
        send(1'b1, 1'b0, 1'b1, 1'b0, jefe, tc2);
        chk("tc2_384_tv_clr", tag_valid, 1'b0);
        wait_tag("tc2_384_done");
        chk("tc2_384_tag", {128'b0, tag[511:128]}, {128'b0, TC2_384});

        // 3-block session
        exp3 = hmac_model(1'b1, key3, {b0, b1, b2}, 3);
        send(1'b1, 1'b0, 1'b0, 1'b1, key3, b0);
        wait_ready("m3_wait1");
        chk("m3_tv1", tag_valid, 1'b0);
        chk("m3_cnt1", blk_cnt, 16'd1);
        send(1'b0, 1'b1, 1'b0, 1'b0, key3, b1);
        wait_ready("m3_wait2");
        chk("m3_tv2", tag_valid, 1'b0);
        chk("m3_cnt2", blk_cnt, 16'd2);
        send(1'b0, 1'b1, 1'b1, 1'b0, key3, b2);
        wait_tag("m3_done");
        chk("m3_tag", tag, exp3);
        chk("m3_cnt3", blk_cnt, 16'd3);

        // abandon an open session with a fresh init
        send(1'b1, 1'b0, 1'b0, 1'b1, keya, b0);
        wait_ready("ab_wait");
        chk("ab_state", dut.state_q, ST_WAIT);
        send(1'b1, 1'b0, 1'b1, 1'b1, jefe, tc2);
        wait_tag("ab_done");
        chk("ab_tag", tag, TC2_512);
        chk("ab_cnt", blk_cnt, 16'd1);

        // zeroize during the outer hash
        send(1'b1, 1'b0, 1'b1, 1'b1, jefe, tc2);
        for (int c = 0; c < 1000 && dut.state_q != ST_OUTER; c++) tick();
        chk("zz_in_outer", dut.state_q, ST_OUTER);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zz_ready", ready, 1'b1);
        chk("zz_tag_valid", tag_valid, 1'b0);
        chk("zz_blk_cnt", blk_cnt, 16'd0);
`ifdef HMAC_KEY_LATCH_EN
        chk("zz_key_reg", dut.key_q, 512'b0);
`endif
        send(1'b1, 1'b0, 1'b1, 1'b1, jefe, tc2);
        wait_tag("zz_tc2_done");
        chk("zz_tc2_tag", tag, TC2_512);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
